// File: rtl/mp_add_sequencer.sv
// Multi-precision add/subtract sequencer: streams one 32-bit limb per cycle
// (LSB first) through an external 32-bit adder and assembles the wide result.
module mp_add_sequencer #(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_sub,
  input  logic [32*WORDS-1:0]   in_a,
  input  logic [32*WORDS-1:0]   in_b,
  output logic [31:0]           add_a,
  output logic [31:0]           add_b,
  output logic                  add_cin,
  input  logic [31:0]           add_sum,
  input  logic                  add_cout,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [32*WORDS-1:0]   res_sum,
  output logic                  res_cout,
  output logic                  res_ovf
);

  localparam int W  = 32 * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    res_sum_q, res_sum_d;
  logic            res_cout_q, res_cout_d;
  logic            res_ovf_q, res_ovf_d;
  logic            res_valid_q, res_valid_d;
  logic            in_ready_q, in_ready_d;
  logic            accept;
  logic            run_wr;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    a_d         = a_q;
    b_d         = b_q;
    res_cout_d  = res_cout_q;
    res_ovf_d   = res_ovf_q;
    res_valid_d = res_valid_q;
    accept      = 1'b0;
    run_wr      = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // B is pre-inverted for subtraction; the +1 enters as the first carry-in.
          accept  = 1'b1;
          a_d     = in_a;
          b_d     = in_sub ? ~in_b : in_b;
          carry_d = in_sub;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        run_wr  = 1'b1;
        carry_d = add_cout;
        if (idx_q == LAST_IDX) begin
          state_d     = DONE;
          res_valid_d = 1'b1;
          res_cout_d  = add_cout;
          res_ovf_d   = (a_q[W-1] == b_q[W-1]) && (add_sum[31] != a_q[W-1]);
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE);
  end

  // Each limb of the result is cleared on accept and written only in its own RUN cycle.
  generate
    for (genvar gi = 0; gi < WORDS; gi++) begin : g_limb
      assign res_sum_d[32*gi +: 32] =
          accept                             ? 32'd0   :
          (run_wr && (idx_q == IW'(gi)))     ? add_sum :
                                               res_sum_q[32*gi +: 32];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      res_sum_q   <= '0;
      res_cout_q  <= 1'b0;
      res_ovf_q   <= 1'b0;
      res_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_sum_q   <= res_sum_d;
      res_cout_q  <= res_cout_d;
      res_ovf_q   <= res_ovf_d;
      res_valid_q <= res_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  // Adder drive depends only on registered state, never on the live inputs.
  always_comb begin
    add_a   = 32'd0;
    add_b   = 32'd0;
    add_cin = 1'b0;
    if (state_q == RUN) begin
      add_a   = a_q[32*idx_q +: 32];
      add_b   = b_q[32*idx_q +: 32];
      add_cin = carry_q;
    end
  end

  assign in_ready  = in_ready_q;
  assign res_valid = res_valid_q;
  assign res_sum   = res_sum_q;
  assign res_cout  = res_cout_q;
  assign res_ovf   = res_ovf_q;

endmodule
